hashin_deframer: RTL
====================

# hashin_deframer

Consumer end of the hash-input FIFO. Pops 64-bit frames written by the nonce generator: a header word, then ten message words. It rebuilds the 640-bit block header, presents it to the hash core over a valid/ready handshake, and recovers the nonce in native byte order. It also resynchronises after framing errors and drains the FIFO on a stop/flush request.

## Interface
- HDR_WORD, 64'h8000_0000_0000_0280, frame start word (bit 63 marker, low 16 bits = 640-bit message length)
- BODY_WORDS, 10, message words per frame; message width MSG_W = 64*BODY_WORDS
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- fifo_dout  in  64  hashin FIFO data, first-word-fall-through
- fifo_empty  in  1  hashin FIFO empty
- fifo_rd_en  out  1  pop; combinational, never asserted while fifo_empty
- flush  in  1  level request to discard partial frame and drain FIFO
- flush_ack  out  1  high while flushing and FIFO empty
- msg_valid  out  1  msg/msg_nonce valid
- msg_ready  in  1  hash core accepts
- msg  out  MSG_W  block header; first body word in [MSG_W-1:MSG_W-64]
- msg_nonce  out  32  byte-swap of msg[31:0]
- frame_cnt  out  32  frames delivered (wraps)
- frame_err_cnt  out  16  words discarded while hunting (saturates at 16'hFFFF)

## Operation
- States: HUNT, BODY, OUT, FLUSH. Reset → HUNT.
- HUNT: if !fifo_empty, pop.
  - If fifo_dout == HDR_WORD: clear word count, go BODY.
  - Otherwise: frame_err_cnt++ (saturating), stay in HUNT.
- BODY: if !fifo_empty, pop.
  - Shift msg_reg = {msg_reg[MSG_W-65:0], fifo_dout} and increment the count.
  - On the BODY_WORDS-th pop, go OUT.
  - Body words are not compared against HDR_WORD.
  - An empty FIFO simply stalls; there is no timeout.
- OUT: msg_valid=1; msg and msg_nonce are held stable.
  - On msg_valid && msg_ready: frame_cnt++ and go HUNT.
  - No pop occurs in OUT.
- msg_nonce = {msg[7:0], msg[15:8], msg[23:16], msg[31:24]}. This inverts the swap applied by the nonce generator.
- flush has priority over every state transition.
  - If flush=1 in any state, next state is FLUSH.
  - A valid&&ready handshake in the same cycle still completes and is counted.
  - The partial frame is discarded without counting as an error.
- FLUSH: fifo_rd_en = !fifo_empty; msg_valid=0.
  - flush_ack = fifo_empty.
  - When flush falls, go HUNT.
  - Discarded words do not touch frame_err_cnt.
- frame_cnt wraps 32'hFFFFFFFF → 0.

## Timing
- Reset values:
  - fifo_rd_en=0, flush_ack=0, msg_valid=0
  - msg=0, msg_nonce=0
  - frame_cnt=0, frame_err_cnt=0
- fifo_rd_en is a combinational function of state and fifo_empty: asserted in HUNT/BODY/FLUSH whenever !fifo_empty and not blocked by OUT.
- A pop consumes fifo_dout of the same cycle.
- Latency: last body word popped at cycle t → msg_valid=1 at t+1.
- Throughput: 12 cycles per frame minimum with continuous data and msg_ready held high (11 pops + 1 OUT cycle).
- msg_valid stays high until accepted; it is never withdrawn except by flush or rst.
- Reset mid-frame: everything returns to reset values the next cycle. Words already popped are lost; the next frame is found by HUNT.

## Structure
- Package oBTC_pkg holds:
  - HDR_WORD constant and BODY_WORDS default
  - the deframer state enum typedef
- The nonce generator imports the same constants.
- Single module, no sub-module; the counters are inline.

## Test plan
- Single frame, ready held high: push HDR_WORD + words W0..W9 with W9 = 64'h1122334455667788.
  - msg_valid 1 cycle after the 11th pop.
  - msg[639:576]=W0; msg_nonce=32'h88776655.
  - frame_cnt=1.
- Backpressure: msg_ready=0 for 20 cycles with a second frame queued.
  - msg held stable.
  - No pops during OUT.
  - Second frame delivered after acceptance.
- Garbage: push 3 non-header words, then a valid frame.
  - frame_err_cnt=3; frame delivered intact.
- Flush mid-body: flush after 4 body words with 30 words queued.
  - FIFO drained; flush_ack=1 once empty.
  - On release, the next full frame is delivered.
  - frame_cnt and frame_err_cnt unchanged by the flush.
- Gaps: insert random empty cycles between body words.
  - Identical msg; no extra pops.
- Nonce wrap: frame with nonce field 32'hFFFFFFFF (bytes FF FF FF FF).
  - msg_nonce=32'hFFFFFFFF.
- Error counter saturation: preload frame_err_cnt to 16'hFFFF via force, push 2 junk words.
  - Stays at 16'hFFFF.

Source files
------------

// File: rtl/oBTC_pkg.sv
// oBTC_pkg: constants and types shared by the hash-input path.
//   HDR_WORD   - frame start word written ahead of every message
//                (bit 63 marker, low 16 bits = 640-bit message length)
//   BODY_WORDS - 64-bit message words following each header
//   deframer_state_t - state encoding of the hash-input deframer
package oBTC_pkg;

  localparam logic [63:0] HDR_WORD   = 64'h8000_0000_0000_0280;
  localparam int          BODY_WORDS = 10;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    BODY  = 2'd1,
    OUT   = 2'd2,
    FLUSH = 2'd3
  } deframer_state_t;

endpackage

// File: rtl/hashin_deframer.sv
// hashin_deframer: consumer end of the hash-input FIFO.
// Hunts for HDR_WORD, collects N_WORDS body words into a block header,
// offers it to the hash core over valid/ready, and recovers the nonce in
// native byte order. A flush request discards any partial frame and drains
// the FIFO.
//
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   fifo_dout      - FIFO head word (first-word-fall-through)
//   fifo_empty     - FIFO empty flag
//   fifo_rd_en     - pop strobe (combinational, never while fifo_empty)
//   flush          - level request: discard partial frame, drain FIFO
//   flush_ack      - high while flushing and FIFO is empty
//   msg_valid      - msg / msg_nonce valid
//   msg_ready      - hash core accepts msg
//   msg            - block header, first body word in the top 64 bits
//   msg_nonce      - byte-swapped msg[31:0]
//   frame_cnt      - frames delivered (wraps)
//   frame_err_cnt  - words discarded while hunting (saturates)
module hashin_deframer
  import oBTC_pkg::*;
#(
  parameter int N_WORDS = BODY_WORDS,
  localparam int MSG_W  = 64 * N_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             flush_ack,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [MSG_W-1:0] msg,
  output logic [31:0]      msg_nonce,
  output logic [31:0]      frame_cnt,
  output logic [15:0]      frame_err_cnt
);

  localparam int CNT_W = $clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  deframer_state_t state_q, state_d;
  logic [CNT_W-1:0] word_cnt;
  logic [MSG_W-1:0] msg_q;

  logic pop_hdr;
  logic pop_junk;
  logic pop_body;
  logic accept;

  // Next-state and strobe decode. A pop taken in the same cycle as a flush
  // request is simply thrown away: it neither shifts into the message nor
  // counts as a hunting error.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    flush_ack  = 1'b0;
    msg_valid  = 1'b0;
    pop_hdr    = 1'b0;
    pop_junk   = 1'b0;
    pop_body   = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      HUNT: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty && !flush) begin
          if (fifo_dout == HDR_WORD) begin
            pop_hdr = 1'b1;
            state_d = BODY;
          end else begin
            pop_junk = 1'b1;
          end
        end
      end
      BODY: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty && !flush) begin
          pop_body = 1'b1;
          if (word_cnt == LAST_IDX) state_d = OUT;
        end
      end
      OUT: begin
        msg_valid = 1'b1;
        if (msg_ready) begin
          accept  = 1'b1;
          state_d = HUNT;
        end
      end
      FLUSH: begin
        fifo_rd_en = !fifo_empty;
        flush_ack  = fifo_empty;
        if (!flush) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    // Flush overrides every transition; a handshake in the same cycle
    // has already been flagged above and still counts.
    if (flush) state_d = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      word_cnt      <= '0;
      msg_q         <= '0;
      frame_cnt     <= '0;
      frame_err_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (pop_hdr) word_cnt <= '0;
      if (pop_body) begin
        msg_q    <= {msg_q[MSG_W-65:0], fifo_dout};
        word_cnt <= word_cnt + 1'b1;
      end
      if (pop_junk && frame_err_cnt != 16'hFFFF)
        frame_err_cnt <= frame_err_cnt + 16'd1;
      if (accept) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  assign msg = msg_q;

  // The nonce generator stores the nonce big-endian in the last word;
  // swapping the bytes back gives the native value.
  assign msg_nonce = {msg_q[7:0], msg_q[15:8], msg_q[23:16], msg_q[31:24]};

endmodule
